// File: rtl/if_stage_pkg.sv
// if_stage_pkg
// Constants and helpers shared by the instruction-fetch stage and by the later
// stages that compare against the same instruction-cycle count values.
//   - Bus widths (BUS_8/BUS_32/BUS_64) and the instruction width (INST_W)
//   - Default reset PC and the CYCLE_LEN / ID_CNT / WB_CNT count values
//   - pc_sel_e: source of the next PC at the end of an instruction cycle
//   - select_word(): picks the 32-bit instruction out of a fetched doubleword
package if_stage_pkg;

  localparam int BUS_8  = 8;
  localparam int BUS_32 = 32;
  localparam int BUS_64 = 64;
  localparam int INST_W = 32;

  localparam logic [BUS_64-1:0] RESET_PC_DEF  = 64'h0000_0000_8000_0000;
  localparam int                CYCLE_LEN_DEF = 8;
  localparam int                ID_CNT_DEF    = 4;
  localparam int                WB_CNT_DEF    = 7;

  // Count values with a fixed role regardless of cycle length.
  localparam logic [BUS_8-1:0] CNT_LAUNCH = 8'd0;
  localparam logic [BUS_8-1:0] CNT_FETCH  = 8'd1;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_SEQ,
    PC_JUMP
  } pc_sel_e;

  // The fetch bus returns an aligned doubleword; pc[2] selects which half
  // holds the instruction.
  function automatic logic [INST_W-1:0] select_word(input logic             upper,
                                                    input logic [BUS_64-1:0] dword);
    return upper ? dword[63:32] : dword[31:0];
  endfunction

endpackage

// File: rtl/if_stage_instcycle_cnt.sv
// instcycle_cnt
// Per-instruction phase counter shared by every pipeline stage.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   fetch_done    : the fetch at count 1 completed this cycle (allows 1 -> 2)
//   stall         : holds the count while it is in ID_CNT+1..WB_CNT
//   cnt           : current count, 0..CYCLE_LEN-1
//   wrap          : strobe, high in the cycle that leaves WB_CNT for 0
module instcycle_cnt
  import if_stage_pkg::*;
#(
  parameter int CYCLE_LEN = CYCLE_LEN_DEF,
  parameter int ID_CNT    = ID_CNT_DEF,
  parameter int WB_CNT    = WB_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_done,
  input  logic             stall,
  output logic [BUS_8-1:0] cnt,
  output logic             wrap
);

  localparam logic [BUS_8-1:0] ID8   = BUS_8'(ID_CNT);
  localparam logic [BUS_8-1:0] WB8   = BUS_8'(WB_CNT);
  localparam logic [BUS_8-1:0] LAST8 = BUS_8'(CYCLE_LEN - 1);

  logic in_stall_window;

  assign in_stall_window = (cnt > ID8) && (cnt <= WB8);
  assign wrap            = (cnt == WB8) && !stall;

  // Count 1 waits for the fetch (a faulted fetch never completes, so the
  // counter parks there), the post-decode window honours stall, and every
  // other count advances unconditionally. The final branch also keeps the
  // count inside 0..CYCLE_LEN-1 if WB_CNT is not the last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= CNT_LAUNCH;
    end else if (cnt == CNT_FETCH) begin
      if (fetch_done) cnt <= cnt + 8'd1;
    end else if (in_stall_window) begin
      if (!stall) cnt <= (cnt == WB8) ? CNT_LAUNCH : cnt + 8'd1;
    end else if (cnt >= LAST8) begin
      cnt <= CNT_LAUNCH;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// if_stage
// Instruction-fetch stage of the multi-cycle RV64 core. Owns the architectural
// PC and the instruction-cycle counter; fetches one instruction per cycle.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   instcycle_cnt_val  : current phase of the instruction cycle
//   pc                 : address of the instruction held in inst
//   inst, inst_valid   : fetched instruction and its valid flag
//   if_req, if_addr    : fetch request and 8-byte-aligned fetch address
//   if_ack, if_rdata   : memory acknowledge and returned doubleword
//   jmp_en, jmp_addr   : redirect from execute, honoured only at WB_CNT
//   stall              : holds the counter in ID_CNT+1..WB_CNT
//   fetch_fault        : sticky misaligned-PC flag, cleared only by rst
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = RESET_PC_DEF,
  parameter int          CYCLE_LEN = CYCLE_LEN_DEF,
  parameter int          ID_CNT    = ID_CNT_DEF,
  parameter int          WB_CNT    = WB_CNT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [BUS_8-1:0]  instcycle_cnt_val,
  output logic [BUS_64-1:0] pc,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic              if_req,
  output logic [BUS_64-1:0] if_addr,
  input  logic              if_ack,
  input  logic [BUS_64-1:0] if_rdata,
  input  logic              jmp_en,
  input  logic [BUS_64-1:0] jmp_addr,
  input  logic              stall,
  output logic              fetch_fault
);

  logic    fetch_phase;
  logic    misaligned;
  logic    fetch_done;
  logic    wrap;
  logic    unused_jmp_lsb;
  pc_sel_e pc_sel;

  assign fetch_phase    = (instcycle_cnt_val == CNT_FETCH);
  assign misaligned     = (pc[1:0] != 2'b00);
  assign if_req         = fetch_phase && !misaligned;
  assign if_addr        = {pc[63:3], 3'b000};
  assign fetch_done     = if_req && if_ack;
  assign unused_jmp_lsb = jmp_addr[0];

  instcycle_cnt #(
    .CYCLE_LEN (CYCLE_LEN),
    .ID_CNT    (ID_CNT),
    .WB_CNT    (WB_CNT)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .fetch_done (fetch_done),
    .stall      (stall),
    .cnt        (instcycle_cnt_val),
    .wrap       (wrap)
  );

  // The PC only moves on the WB_CNT -> 0 edge; a redirect wins over
  // sequential flow and has its bit 0 cleared like a JALR target.
  always_comb begin
    pc_sel = PC_HOLD;
    if (wrap) pc_sel = jmp_en ? PC_JUMP : PC_SEQ;
  end

  // Architectural PC register; pc + 4 wraps naturally at 64 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      case (pc_sel)
        PC_SEQ:  pc <= pc + 64'd4;
        PC_JUMP: pc <= {jmp_addr[63:1], 1'b0};
        default: pc <= pc;
      endcase
    end
  end

  // Instruction latch: captured only on an acknowledged fetch, so acks
  // arriving at other counts (or after a reset) leave inst untouched.
  // inst_valid drops together with the PC update.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst       <= '0;
      inst_valid <= 1'b0;
    end else if (fetch_done) begin
      inst       <= select_word(pc[2], if_rdata);
      inst_valid <= 1'b1;
    end else if (wrap) begin
      inst_valid <= 1'b0;
    end
  end

  // A misaligned PC at fetch time raises the fault; it stays set until reset
  // while the counter is parked at count 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_fault <= 1'b0;
    end else if (fetch_phase && misaligned) begin
      fetch_fault <= 1'b1;
    end
  end

endmodule
